// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and FSM state encoding for the multi-cycle ALU
//
// Purpose: one place for the operation encoding and the controller state
// names, so the datapath and the controller cannot drift apart.
// Ports: none (package).
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_NOR   = 4'h5,
    ALU_SLL   = 4'h6,
    ALU_SRL   = 4'h7,
    ALU_SRA   = 4'h8,
    ALU_SLT   = 4'h9,
    ALU_SLTU  = 4'hA,
    ALU_PASSB = 4'hB,
    ALU_MULU  = 4'hC,
    ALU_DIVU  = 4'hD
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational single-cycle ALU datapath
//
// Purpose: computes every op that finishes in one cycle. MULU, DIVU and the
// reserved codes yield zero here; the controller handles them.
// Ports:
//   i_op       operation code
//   i_a, i_b   operands
//   o_res      result
//   o_flag_c   ADD carry-out / SUB no-borrow, else 0
//   o_flag_v   ADD/SUB signed overflow, else 0
module alu_comb
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [3:0]   i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_res,
  output logic         o_flag_c,
  output logic         o_flag_v
);

  localparam int SW = $clog2(N);

  logic [N:0]    w_sum;
  logic [N:0]    w_diff;
  logic [SW-1:0] w_sh;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_sh   = i_b[SW-1:0];

  always_comb begin
    o_res    = '0;
    o_flag_c = 1'b0;
    o_flag_v = 1'b0;
    case (i_op)
      ALU_ADD: begin
        o_res    = w_sum[N-1:0];
        o_flag_c = w_sum[N];
        o_flag_v = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
      end
      ALU_SUB: begin
        o_res    = w_diff[N-1:0];
        // The top bit of the widened difference is the borrow.
        o_flag_c = ~w_diff[N];
        o_flag_v = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
      end
      ALU_AND:   o_res = i_a & i_b;
      ALU_OR:    o_res = i_a | i_b;
      ALU_XOR:   o_res = i_a ^ i_b;
      ALU_NOR:   o_res = ~(i_a | i_b);
      ALU_SLL:   o_res = i_a << w_sh;
      ALU_SRL:   o_res = i_a >> w_sh;
      ALU_SRA:   o_res = $signed(i_a) >>> w_sh;
      ALU_SLT:   o_res = {{(N-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU:  o_res = {{(N-1){1'b0}}, (i_a < i_b)};
      ALU_PASSB: o_res = i_b;
      default:   o_res = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with iterative MULU/DIVU and valid/ready handshakes
//
// Purpose: registers single-cycle ALU results and runs unsigned multiply
// (shift-add) and divide (restoring) one bit per clock.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready = state is IDLE)
//   op, a, b             operation code and operands
//   out_valid, out_ready result handshake
//   res, res_hi          result / MUL high half or DIV remainder
//   flag_z/c/v, err      zero, carry, overflow, error (div-by-zero, reserved op)
module alu_mc
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic [N-1:0] res_hi,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         err
);

  localparam int CW = $clog2(N) + 1;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  // r_acc: MUL product high half / DIV partial remainder.
  // r_lo:  MUL multiplier shifting out / DIV dividend shifting out, quotient in.
  // r_opnd: MUL multiplicand / DIV divisor.
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_lo;
  logic [N-1:0]  r_opnd;
  logic [N-1:0]  r_res;
  logic [N-1:0]  r_res_hi;
  logic          r_z;
  logic          r_c;
  logic          r_v;
  logic          r_err;

  logic [N-1:0]  w_comb_res;
  logic          w_comb_c;
  logic          w_comb_v;
  logic          w_accept;
  logic          w_op_rsv;
  logic          w_b_zero;
  logic          w_last;

  logic [N:0]    w_mul_sum;
  logic [N-1:0]  w_mul_acc;
  logic [N-1:0]  w_mul_lo;
  logic [N:0]    w_div_shift;
  logic [N:0]    w_div_diff;
  logic          w_div_ge;
  logic [N-1:0]  w_div_acc;
  logic [N-1:0]  w_div_lo;

  logic          w_ld;
  logic [N-1:0]  w_res_nxt;
  logic [N-1:0]  w_hi_nxt;
  logic          w_c_nxt;
  logic          w_v_nxt;
  logic          w_err_nxt;

  alu_comb #(.N(N)) u_comb (
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_res    (w_comb_res),
    .o_flag_c (w_comb_c),
    .o_flag_v (w_comb_v)
  );

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_op_rsv = (op[3:1] == 3'b111);
  assign w_b_zero = (b == '0);
  assign w_last   = (r_cnt == CW'(1));

  // Shift-add step: conditionally add the multiplicand to the high half,
  // then shift the whole 2N-bit product right by one.
  assign w_mul_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : {(N+1){1'b0}});
  assign w_mul_acc = w_mul_sum[N:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[N-1:1]};

  // Restoring step: the shifted remainder is N+1 bits wide; if it does not
  // fit under the divisor the subtraction wraps and sets the top bit.
  assign w_div_shift = {r_acc, r_lo[N-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ge    = ~w_div_diff[N];
  assign w_div_acc   = w_div_ge ? w_div_diff[N-1:0] : w_div_shift[N-1:0];
  assign w_div_lo    = {r_lo[N-2:0], w_div_ge};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (op == ALU_MULU)                    w_state_nxt = S_MUL;
          else if (op == ALU_DIVU && !w_b_zero)  w_state_nxt = S_DIV;
          else                                   w_state_nxt = S_DONE;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Result selection: which value lands in the output registers, and when.
  always_comb begin
    w_ld      = 1'b0;
    w_res_nxt = w_comb_res;
    w_hi_nxt  = '0;
    w_c_nxt   = 1'b0;
    w_v_nxt   = 1'b0;
    w_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_op_rsv) begin
            w_ld      = 1'b1;
            w_res_nxt = '0;
            w_err_nxt = 1'b1;
          end else if (op == ALU_DIVU && w_b_zero) begin
            w_ld      = 1'b1;
            w_res_nxt = '1;
            w_hi_nxt  = a;
            w_err_nxt = 1'b1;
          end else if (op != ALU_MULU && op != ALU_DIVU) begin
            w_ld      = 1'b1;
            w_c_nxt   = w_comb_c;
            w_v_nxt   = w_comb_v;
          end
        end
      end
      S_MUL: begin
        if (w_last) begin
          w_ld      = 1'b1;
          w_res_nxt = w_mul_lo;
          w_hi_nxt  = w_mul_acc;
        end
      end
      S_DIV: begin
        if (w_last) begin
          w_ld      = 1'b1;
          w_res_nxt = w_div_lo;
          w_hi_nxt  = w_div_acc;
        end
      end
      default: w_ld = 1'b0;
    endcase
  end

  // Iterative datapath and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc  <= '0;
            r_cnt  <= CW'(N);
            r_lo   <= (op == ALU_MULU) ? b : a;
            r_opnd <= (op == ALU_MULU) ? a : b;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_lo  <= w_mul_lo;
          r_cnt <= r_cnt - CW'(1);
        end
        S_DIV: begin
          r_acc <= w_div_acc;
          r_lo  <= w_div_lo;
          r_cnt <= r_cnt - CW'(1);
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Output registers; only written on a load, so DONE holds them stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res    <= '0;
      r_res_hi <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_ld) begin
      r_res    <= w_res_nxt;
      r_res_hi <= w_hi_nxt;
      r_z      <= (w_res_nxt == '0);
      r_c      <= w_c_nxt;
      r_v      <= w_v_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign res    = r_res;
  assign res_hi = r_res_hi;
  assign flag_z = r_z;
  assign flag_c = r_c;
  assign flag_v = r_v;
  assign err    = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc at N=32 and N=8
module tb_alu_mc;

  // Expected response; fl = {flag_z, flag_c, flag_v, err}.
  // lat = clock edges between the accept edge and the edge that raises out_valid.
  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_edge[2];
  bit   prev_ov[2];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv, ir, ov, ordy, z, c, v, er;
  logic [3:0]  op;
  logic [31:0] a, b, res, hi;

  logic        iv8, ir8, ov8, ordy8, z8, c8, v8, er8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8, hi8;

  alu_mc #(.N(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .op(op), .a(a), .b(b),
    .out_valid(ov), .out_ready(ordy), .res(res), .res_hi(hi),
    .flag_z(z), .flag_c(c), .flag_v(v), .err(er)
  );

  alu_mc #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(ordy8), .res(res8), .res_hi(hi8),
    .flag_z(z8), .flag_c(c8), .flag_v(v8), .err(er8)
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t E(input logic [31:0] r, input logic [31:0] h,
                             input logic [3:0] fl, input int lat);
    exp_t e;
    e.res = r; e.hi = h; e.fl = fl; e.lat = lat;
    return e;
  endfunction

  // Monitor step for one DUT: checks on the first out_valid cycle, checks
  // stability on every later one, pops on the handshake.
  task automatic mon(input int id, input logic iv_, input logic ir_, input logic ov_,
                     input logic or_, input logic [31:0] r, input logic [31:0] h,
                     input logic [3:0] fl);
    exp_t e;
    if (ov_) begin
      if ((id == 0 && q32.size() == 0) || (id == 1 && q8.size() == 0)) begin
        chk($sformatf("dut%0d unexpected output", id), 72'd1, 72'd0);
      end else begin
        e = (id == 1) ? q8[0] : q32[0];
        if (!prev_ov[id]) begin
          chk($sformatf("dut%0d res", id), 72'(r), 72'(e.res));
          chk($sformatf("dut%0d res_hi", id), 72'(h), 72'(e.hi));
          chk($sformatf("dut%0d flags", id), 72'(fl), 72'(e.fl));
          chk($sformatf("dut%0d latency", id), 72'(cyc - acc_edge[id]), 72'(e.lat));
        end else begin
          chk($sformatf("dut%0d hold", id), {4'h0, fl, r, h}, {4'h0, e.fl, e.res, e.hi});
        end
        if (or_) begin
          if (id == 1) void'(q8.pop_front());
          else         void'(q32.pop_front());
        end
      end
    end
    if (iv_ && ir_) acc_edge[id] = cyc + 1;
    prev_ov[id] = ov_;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov[0] = 1'b0;
      prev_ov[1] = 1'b0;
    end else begin
      mon(0, iv, ir, ov, ordy, res, hi, {z, c, v, er});
      mon(1, iv8, ir8, ov8, ordy8, {24'h0, res8}, {24'h0, hi8}, {z8, c8, v8, er8});
    end
  end

  // Issue one op; called #1 after a rising edge, returns #1 after an edge.
  // Operands are scrambled right after the accept edge.
  task automatic go32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input exp_t e, input bit push, input bit wt);
    bit ok = 1'b0;
    op = o; a = x; b = y; iv = 1'b1;
    if (push) q32.push_back(e);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); ok = ir;
      @(posedge clk);
    end
    #1 iv = 1'b0; op = 4'hE; a = 32'h5A5A5A5A; b = 32'hA5A5A5A5;
    if (!ok) chk("dut0 accept timeout", 72'd0, 72'd1);
    if (wt) begin
      for (int n = 0; n < 100 && q32.size() != 0; n++) begin
        @(posedge clk); #1;
      end
      if (q32.size() != 0) chk("dut0 result timeout", 72'(q32.size()), 72'd0);
    end
  endtask

  task automatic go8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                     input exp_t e);
    bit ok = 1'b0;
    op8 = o; a8 = x; b8 = y; iv8 = 1'b1;
    q8.push_back(e);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); ok = ir8;
      @(posedge clk);
    end
    #1 iv8 = 1'b0; op8 = 4'hE; a8 = 8'h5A; b8 = 8'hA5;
    if (!ok) chk("dut1 accept timeout", 72'd0, 72'd1);
    for (int n = 0; n < 100 && q8.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    if (q8.size() != 0) chk("dut1 result timeout", 72'(q8.size()), 72'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    iv = 1'b0; ordy = 1'b1; op = 4'h0; a = '0; b = '0;
    iv8 = 1'b0; ordy8 = 1'b1; op8 = 4'h0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset handshake", {70'h0, ir, ov}, 72'b10);
    chk("reset outputs", {4'h0, z, c, v, er, res, hi}, 72'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //   op     a             b             res           res_hi        zcve     lat
    go32(4'h0, 32'hFFFFFFFF, 32'h00000001, E(32'h00000000, 32'h0, 4'b1100, 0), 1, 1);
    go32(4'h0, 32'h7FFFFFFF, 32'h00000001, E(32'h80000000, 32'h0, 4'b0010, 0), 1, 1);
    go32(4'h1, 32'h00000005, 32'h00000003, E(32'h00000002, 32'h0, 4'b0100, 0), 1, 1);
    go32(4'h1, 32'h00000003, 32'h00000005, E(32'hFFFFFFFE, 32'h0, 4'b0000, 0), 1, 1);
    go32(4'h1, 32'h80000000, 32'h00000001, E(32'h7FFFFFFF, 32'h0, 4'b0110, 0), 1, 1);
    go32(4'h1, 32'h00000007, 32'h00000007, E(32'h00000000, 32'h0, 4'b1100, 0), 1, 1);
    go32(4'h2, 32'hF0F0F0F0, 32'h0FF00FF0, E(32'h00F000F0, 32'h0, 4'b0000, 0), 1, 1);
    go32(4'h3, 32'hF0F0F0F0, 32'h0FF00FF0, E(32'hFFF0FFF0, 32'h0, 4'b0000, 0), 1, 1);
    go32(4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, E(32'hFF00FF00, 32'h0, 4'b0000, 0), 1, 1);
    go32(4'h5, 32'hF0F0F0F0, 32'h0FF00FF0, E(32'h000F000F, 32'h0, 4'b0000, 0), 1, 1);
    go32(4'h6, 32'h00000001, 32'h00000021, E(32'h00000002, 32'h0, 4'b0000, 0), 1, 1);
    go32(4'h7, 32'h80000000, 32'h0000001F, E(32'h00000001, 32'h0, 4'b0000, 0), 1, 1);
    go32(4'h8, 32'h80000000, 32'h00000004, E(32'hF8000000, 32'h0, 4'b0000, 0), 1, 1);
    go32(4'h9, 32'hFFFFFFFF, 32'h00000001, E(32'h00000001, 32'h0, 4'b0000, 0), 1, 1);
    go32(4'hA, 32'hFFFFFFFF, 32'h00000001, E(32'h00000000, 32'h0, 4'b1000, 0), 1, 1);
    go32(4'hB, 32'h00000000, 32'hDEADBEEF, E(32'hDEADBEEF, 32'h0, 4'b0000, 0), 1, 1);
    go32(4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, E(32'h00000001, 32'hFFFFFFFE, 4'b0000, 32), 1, 1);
    go32(4'hC, 32'h00010000, 32'h00010000, E(32'h00000000, 32'h00000001, 4'b1000, 32), 1, 1);
    go32(4'hD, 32'd100,      32'd7,        E(32'd14,        32'd2,        4'b0000, 32), 1, 1);
    go32(4'hD, 32'd3,        32'd10,       E(32'd0,         32'd3,        4'b1000, 32), 1, 1);
    go32(4'hD, 32'hFFFFFFFF, 32'h00000001, E(32'hFFFFFFFF, 32'h00000000, 4'b0000, 32), 1, 1);
    go32(4'hE, 32'h00000001, 32'h00000002, E(32'h00000000, 32'h0, 4'b1001, 0), 1, 1);
    go32(4'hD, 32'd5,        32'd0,        E(32'hFFFFFFFF, 32'd5,        4'b0001, 0), 1, 1);

    // Reset in the middle of a MULU: the held DIVU-by-zero result must vanish.
    go32(4'hC, 32'd7, 32'd9, E(32'd63, 32'd0, 4'b0000, 32), 0, 0);
    repeat (4) @(posedge clk);
    #3;
    chk("busy mid-mul", {71'h0, ir}, 72'd0);
    rst_n = 1'b0;
    #1;
    chk("async reset handshake", {70'h0, ir, ov}, 72'b10);
    chk("async reset outputs", {4'h0, z, c, v, er, res, hi}, 72'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    go32(4'h0, 32'd3, 32'd4, E(32'd7, 32'd0, 4'b0000, 0), 1, 1);

    // Back-pressure with a competing request that must not be accepted.
    ordy = 1'b0;
    go32(4'h8, 32'h80000000, 32'h00000024, E(32'hF8000000, 32'h0, 4'b0000, 0), 1, 0);
    iv = 1'b1; op = 4'h0; a = 32'd1; b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("backpressure hold", {38'h0, ov, ir, res}, {38'h0, 1'b1, 1'b0, 32'hF8000000});
    end
    @(posedge clk); #1;
    ordy = 1'b1; iv = 1'b0;
    @(posedge clk); #1;
    chk("release to idle", {70'h0, ir, ov}, 72'b10);
    chk("backpressure drained", 72'(q32.size()), 72'd0);

    // Narrow instance.
    go8(4'h9, 8'h80, 8'h01, E(32'h01, 32'h00, 4'b0000, 0));
    go8(4'hA, 8'h80, 8'h01, E(32'h00, 32'h00, 4'b1000, 0));
    go8(4'hF, 8'h12, 8'h34, E(32'h00, 32'h00, 4'b1001, 0));
    go8(4'h0, 8'hFF, 8'h01, E(32'h00, 32'h00, 4'b1100, 0));
    go8(4'hC, 8'hFF, 8'hFF, E(32'h01, 32'hFE, 4'b0000, 8));
    go8(4'hD, 8'd200, 8'd9, E(32'd22, 32'd2,  4'b0000, 8));

    repeat (3) @(posedge clk);
    #1;
    chk("queues empty", 72'(q32.size() + q8.size()), 72'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
